id_fwd_interlock: RTL
=====================

Name: id_fwd_interlock

Overview:
Parametrised successor to the decode-stage operand path of the 5-stage MIPS pipeline. It owns the IF/ID pipeline register and an instruction hold buffer that keeps the instruction valid across stalls. It also owns an N-source priority forwarding network, a load-use interlock that raises stallreq, and branch/jump resolution in ID for beq, bne, bgez, bltz, bgtz, blez, j, jal, jr and jalr. Full ALU/memory decode stays downstream and consumes id_inst.

Parameters:
NUM_FWD, 3, number of forwarding sources; index 0 = youngest (EX), NUM_FWD-1 = oldest (WB).
STALL_W, 6, width of the stall bus.
HOLD_EN, 1, 1 instantiates the instruction hold buffer; 0 passes inst_sram_rdata straight through.
CNT_W, 16, width of the interlock performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  STALL_W  pipeline stall bus; bit1 = IF/ID, bit2 = ID/EX; 1 = Stop.
- flush  in  1  exception flush; kills the ID contents.
- if_to_id_bus  in  33  {ce, pc[31:0]}.
- inst_sram_rdata  in  32  instruction for the PC latched in the previous cycle.
- fwd_we  in  NUM_FWD  per-source register write enable.
- fwd_waddr  in  5*NUM_FWD  per-source destination; source i occupies bits [5i+4:5i].
- fwd_wdata  in  32*NUM_FWD  per-source result.
- fwd_pending  in  NUM_FWD  1 = source result not yet available (load in flight).
- rf_raddr1  out  5  equals rs.
- rf_raddr2  out  5  equals rt.
- rf_rdata1  in  32  regfile read data for rs.
- rf_rdata2  in  32  regfile read data for rt.
- id_valid  out  1  ID holds a live instruction.
- id_pc  out  32  PC of the ID instruction.
- id_inst  out  32  instruction word.
- src1_data  out  32  forwarded rs value.
- src2_data  out  32  forwarded rt value.
- stallreq  out  1  load-use interlock request.
- br_e  out  1  branch/jump taken.
- br_addr  out  32  target address.
- interlock_cnt  out  CNT_W  saturating count of interlock cycles.

Behaviour:
- Pipeline register, evaluated in priority order:
  - rst: clear to 0.
  - flush: valid <= 0.
  - stall[1]=Stop and stall[2]=NoStop: insert a bubble, valid <= 0.
  - stall[1]=NoStop: load if_to_id_bus.
  - Otherwise: hold.
- id_valid = registered ce; id_pc = registered pc.
- Hold buffer (HOLD_EN=1):
  - Capture: on the first cycle with stall[1]=Stop and hold_vld=0, capture inst_sram_rdata into inst_hold and set hold_vld <= 1.
  - Clear: hold_vld clears on rst, flush, bubble insertion, or any register load.
  - Output: id_inst = hold_vld ? inst_hold : inst_sram_rdata.
- All id_* outputs, br_e, stallreq and the forwarded data read as 0 when id_valid=0.
- Forwarding (combinational, per operand):
  - Source i matches when fwd_we[i]=1 and fwd_waddr_i equals the register and the register is nonzero.
  - The lowest matching index wins. With no match the regfile data is used. Register 0 always yields 0.
  - A winning match with fwd_pending[i]=1 marks the operand as not ready. A pending source shadowed by a younger non-pending match is ignored.
- Operand usage:
  - rs is used by every instruction except j, jal, lui, sll, srl and sra.
  - rt is used by R-type ALU/shift ops, beq, bne and sw.
- stallreq = id_valid and ((rs used and rs not ready) or (rt used and rt not ready)). It is combinational, with no added latency.
- Branch resolution:
  - br_e is gated by id_valid, !stallreq and !flush.
  - beq: src1==src2. bne: src1!=src2.
  - bgez, bltz, bgtz, blez: signed compare of src1 against 0.
  - Conditional target = id_pc + 4 + (sext(imm) << 2), 32-bit wrap-around.
  - j, jal: target = {pc_plus4[31:28], index, 2'b00}.
  - jr, jalr: target = src1_data.
  - When br_e=0, br_addr = 0.
- interlock_cnt:
  - Reset to 0.
  - Increments on every cycle where stallreq=1.
  - Saturates at all-ones and never wraps.
- Simultaneous events: flush beats a stall; rst beats everything.
- A stall that ends in the same cycle as a flush leaves valid=0 and hold_vld=0.

Decomposition:
- Shared package/defines: StallBus width, Stop/NoStop, opcode and func constants for branches and jumps, IF_TO_ID_WD.
- One natural sub-module, id_fwd_mux: a priority forwarding mux parametrised by NUM_FWD. It outputs data and a ready flag and is instantiated twice, once for rs and once for rt.

Test Plan:
1. Source 0 writes $5=0x11 and source 2 writes $5=0x22, then ID executes addu $3,$5,$0 -> src1_data=0x11, stallreq=0.
2. lw $4 in source 0 (pending=1), then ID executes beq $4,$4 -> stallreq=1 and br_e=0 for one cycle; next cycle source 1 supplies the data with pending=0 -> br_e=1, br_addr=pc+4+(imm<<2); interlock_cnt=1.
3. Hold buffer: stall[1]=Stop for 3 cycles while inst_sram_rdata changes after cycle 1 -> id_inst stays at the cycle-1 word (e.g. 0x1085FFFF), hold_vld=1.
4. bltz with src1=0x80000000 at pc=0x00000010, imm=0xFFFF -> br_e=1, br_addr=0x00000010.
5. fwd_we=1, waddr=0, wdata=0xDEAD with rs=0 -> src1_data=0.
6. flush asserted during stall with a pending match -> next cycle id_valid=0, stallreq=0, br_e=0; interlock_cnt held at CNT_W'hFFFF stays saturated.

Source files
------------

// File: rtl/id_fwd_interlock_pkg.sv
// Shared constants and types for the ID-stage operand path: stall bus
// encoding, branch/jump opcodes and the IF->ID payload.
package id_fwd_interlock_pkg;

    localparam int unsigned IF_TO_ID_WD = 33;
    localparam int unsigned STALL_W_DEF = 6;
    localparam int unsigned STALL_IF_ID = 1;
    localparam int unsigned STALL_ID_EX = 2;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    // PC-relative branch target: pc+4 plus the sign-extended word offset.
    function automatic logic [31:0] br_target(input logic [31:0] pc_plus4,
                                              input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/id_fwd_interlock_fwd_mux.sv
// Priority forwarding mux for one source operand.
// Ports: reg_addr (operand register), fwd_we/fwd_waddr/fwd_wdata/fwd_pending
// (per-source bypass, index 0 youngest), rf_rdata (regfile fallback),
// data_c (forwarded value), ready_c (0 when the winning source is pending).
module id_fwd_mux #(
    parameter int unsigned NUM_FWD = 3
) (
    input  logic [4:0]            reg_addr,
    input  logic [NUM_FWD-1:0]    fwd_we,
    input  logic [5*NUM_FWD-1:0]  fwd_waddr,
    input  logic [32*NUM_FWD-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]    fwd_pending,
    input  logic [31:0]           rf_rdata,
    output logic [31:0]           data_c,
    output logic                  ready_c
);

    // First hit from the youngest end wins; older sources are shadowed.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        data_c  = rf_rdata;
        ready_c = 1'b1;
        for (int i = 0; i < int'(NUM_FWD); i++) begin
            if (!hit && fwd_we[i] && (fwd_waddr[5*i +: 5] == reg_addr)) begin
                hit     = 1'b1;
                data_c  = fwd_wdata[32*i +: 32];
                ready_c = !fwd_pending[i];
            end
        end
        if (reg_addr == 5'd0) begin
            data_c  = 32'd0;
            ready_c = 1'b1;
        end
    end

endmodule

// File: rtl/id_fwd_interlock.sv
// Decode-stage operand path: IF/ID register with instruction hold buffer,
// rs/rt forwarding, load-use interlock and branch/jump resolution in ID.
// Ports: clk/rst (sync active-high), stall bus, flush, if_to_id_bus {ce,pc},
// inst_sram_rdata, forwarding sources, regfile read port, decoded ID outputs,
// forwarded operands, stallreq, br_e/br_addr and a saturating interlock count.
module id_fwd_interlock
    import id_fwd_interlock_pkg::*;
#(
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned STALL_W = STALL_W_DEF,
    parameter int unsigned HOLD_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    input  logic [31:0]            inst_sram_rdata,
    input  logic [NUM_FWD-1:0]     fwd_we,
    input  logic [5*NUM_FWD-1:0]   fwd_waddr,
    input  logic [32*NUM_FWD-1:0]  fwd_wdata,
    input  logic [NUM_FWD-1:0]     fwd_pending,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    output logic                   id_valid,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_inst,
    output logic [31:0]            src1_data,
    output logic [31:0]            src2_data,
    output logic                   stallreq,
    output logic                   br_e,
    output logic [31:0]            br_addr,
    output logic [CNT_W-1:0]       interlock_cnt
);

    if_to_id_t   id_reg;
    logic        hold_vld;
    logic [31:0] inst_hold;
    logic        stop_if, bubble, load;
    logic [4:0]  rs, rt;
    logic [5:0]  op, fn;
    logic [31:0] rs_data, rt_data, pc_plus4, target;
    logic        rs_ready, rt_ready, rs_used, rt_used, taken;
    logic        stall_unused;

    assign stall_unused = ^{stall[STALL_W-1:STALL_ID_EX+1], stall[0]};

    assign stop_if = (stall[STALL_IF_ID] == STOP);
    assign bubble  = stop_if && (stall[STALL_ID_EX] == NO_STOP);
    assign load    = !stop_if;

    // IF/ID pipeline register; flush outranks any stall combination.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_reg <= '0;
        end else if (flush || bubble) begin
            id_reg.ce <= 1'b0;
        end else if (load) begin
            id_reg <= if_to_id_t'(if_to_id_bus);
        end
    end

    // Instruction SRAM data is only valid the cycle after the fetch, so the
    // word is latched on the first stalled cycle and replayed until release.
    if (HOLD_EN != 0) begin : g_hold
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_vld  <= 1'b0;
                inst_hold <= 32'd0;
            end else if (flush || bubble || load) begin
                hold_vld <= 1'b0;
            end else if (!hold_vld) begin
                hold_vld  <= 1'b1;
                inst_hold <= inst_sram_rdata;
            end
        end
    end else begin : g_no_hold
        assign hold_vld  = 1'b0;
        assign inst_hold = 32'd0;
    end

    assign id_valid = id_reg.ce;
    assign id_pc    = id_valid ? id_reg.pc : 32'd0;
    assign id_inst  = id_valid ? (hold_vld ? inst_hold : inst_sram_rdata) : 32'd0;

    assign op        = id_inst[31:26];
    assign fn        = id_inst[5:0];
    assign rs        = id_inst[25:21];
    assign rt        = id_inst[20:16];
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;
    assign pc_plus4  = id_pc + 32'd4;

    id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs (
        .reg_addr    (rs),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_pending (fwd_pending),
        .rf_rdata    (rf_rdata1),
        .data_c      (rs_data),
        .ready_c     (rs_ready)
    );

    id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rt (
        .reg_addr    (rt),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_pending (fwd_pending),
        .rf_rdata    (rf_rdata2),
        .data_c      (rt_data),
        .ready_c     (rt_ready)
    );

    // Operand usage and branch/jump decision.
    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        taken   = 1'b0;
        target  = br_target(pc_plus4, id_inst[15:0]);
        case (op)
            OP_SPECIAL: begin
                rt_used = 1'b1;
                if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA) begin
                    rs_used = 1'b0;
                end
                if (fn == FN_JR || fn == FN_JALR) begin
                    rt_used = 1'b0;
                    taken   = 1'b1;
                    target  = rs_data;
                end
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZ)      taken = !rs_data[31];
                else if (rt == RT_BLTZ) taken = rs_data[31];
            end
            OP_BEQ: begin
                rt_used = 1'b1;
                taken   = (rs_data == rt_data);
            end
            OP_BNE: begin
                rt_used = 1'b1;
                taken   = (rs_data != rt_data);
            end
            OP_BGTZ: taken = !rs_data[31] && (rs_data != 32'd0);
            OP_BLEZ: taken = rs_data[31] || (rs_data == 32'd0);
            OP_J, OP_JAL: begin
                rs_used = 1'b0;
                taken   = 1'b1;
                target  = {pc_plus4[31:28], id_inst[25:0], 2'b00};
            end
            OP_LUI: rs_used = 1'b0;
            OP_SW:  rt_used = 1'b1;
            default: ;
        endcase
    end

    assign stallreq  = id_valid && ((rs_used && !rs_ready) || (rt_used && !rt_ready));
    assign src1_data = id_valid ? rs_data : 32'd0;
    assign src2_data = id_valid ? rt_data : 32'd0;
    assign br_e      = id_valid && !stallreq && !flush && taken;
    assign br_addr   = br_e ? target : 32'd0;

    // Saturating interlock-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            interlock_cnt <= '0;
        end else if (stallreq && (interlock_cnt != {CNT_W{1'b1}})) begin
            interlock_cnt <= interlock_cnt + CNT_W'(1);
        end
    end

endmodule
